dcache_write_buffer: RTL and testbench

//  Write-back queue between the data cache and the AXI bridge data-write port.

---
 rtl/dcache_write_buffer_if.sv | 38 +++
 rtl/dcache_write_buffer.sv | 123 ++++++++++++
 tb/tb_dcache_write_buffer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_write_buffer_if.sv
// dcache <-> write buffer <-> bridge data-write bundle.
// The slave modport faces the write buffer.
interface dcache_write_buffer_if #(
  parameter int LINE_WIDTH = 256
);
  logic                  wb_req;
  logic [2:0]            wb_type;
  logic [31:0]           wb_addr;
  logic [3:0]            wb_wstrb;
  logic [LINE_WIDTH-1:0] wb_data;
  logic                  wb_rdy;
  logic                  data_wr_req;
  logic [2:0]            data_wr_type;
  logic [31:0]           data_wr_addr;
  logic [3:0]            data_wr_wstrb;
  logic [LINE_WIDTH-1:0] data_wr_data;
  logic                  data_wr_rdy;

  modport slave (
    input  wb_req, wb_type, wb_addr,
    input  wb_wstrb, wb_data,
    output wb_rdy,
    output data_wr_req, data_wr_type,
    output data_wr_addr, data_wr_wstrb,
    output data_wr_data,
    input  data_wr_rdy
  );

  modport master (
    output wb_req, wb_type, wb_addr,
    output wb_wstrb, wb_data,
    input  wb_rdy,
    input  data_wr_req, data_wr_type,
    input  data_wr_addr, data_wr_wstrb,
    input  data_wr_data,
    output data_wr_rdy
  );
endinterface

// File: rtl/dcache_write_buffer.sv
// In-order dcache write-back queue with read-hazard detection.
// Define WB_MERGE_EN to fold line writes into a queued same-line entry.
module dcache_write_buffer #(
  parameter int LINE_WIDTH  = 256,
  parameter int DEPTH       = 4,
  parameter int OFFSET_BITS = 5
) (
  input  logic                  clk,
  input  logic                  resetn,
  dcache_write_buffer_if.slave  bus,
  input  logic                  bridge_empty,
  input  logic [31:0]           rd_chk_addr,
  output logic                  rd_chk_hit,
  output logic                  all_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [2:0] T_LINE = 3'b100;

  typedef struct packed {
    logic [2:0]            typ;
    logic [31:0]           addr;
    logic [3:0]            wstrb;
    logic [LINE_WIDTH-1:0] data;
  } wb_ent_t;

  wb_ent_t          mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;
  logic             alloc;
  logic             mrg_hit;
  logic [PW-1:0]    mrg_idx;
  logic             unused_low;

  assign unused_low = ^rd_chk_addr[OFFSET_BITS-1:0];

  assign bus.wb_rdy        = (count != CW'(DEPTH));
  assign bus.data_wr_req   = (count != '0);
  assign bus.data_wr_type  = mem[rd_ptr].typ;
  assign bus.data_wr_addr  = mem[rd_ptr].addr;
  assign bus.data_wr_wstrb = mem[rd_ptr].wstrb;
  assign bus.data_wr_data  = mem[rd_ptr].data;

  assign push  = bus.wb_req & bus.wb_rdy;
  assign pop   = bus.data_wr_req & bus.data_wr_rdy;
  assign alloc = push & ~mrg_hit;

  assign all_empty = (count == '0) & bridge_empty;

`ifdef WB_MERGE_EN
  logic [PW-1:0] mi;

  // Walk oldest to youngest past the head; last match wins.
  always_comb begin
    mrg_hit = 1'b0;
    mrg_idx = '0;
    mi      = '0;
    for (int i = 1; i < DEPTH; i++) begin
      mi = rd_ptr + PW'(i);
      if (vld[mi] && mem[mi].typ == T_LINE &&
          mem[mi].addr[31:OFFSET_BITS] ==
          bus.wb_addr[31:OFFSET_BITS]) begin
        mrg_hit = 1'b1;
        mrg_idx = mi;
      end
    end
    if (!(push && bus.wb_type == T_LINE))
      mrg_hit = 1'b0;
  end
`else
  assign mrg_hit = 1'b0;
  assign mrg_idx = '0;
`endif

  always_comb begin
    rd_chk_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] &&
          mem[i].addr[31:OFFSET_BITS] ==
          rd_chk_addr[31:OFFSET_BITS])
        rd_chk_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      vld    <= '0;
    end else begin
      if (alloc) begin
        wr_ptr      <= wr_ptr + PW'(1);
        vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + PW'(1);
        vld[rd_ptr] <= 1'b0;
      end
      case ({alloc, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload is not reset; valid bits gate every use.
  always_ff @(posedge clk) begin
    if (alloc) begin
      mem[wr_ptr] <= '{typ:   bus.wb_type,
                       addr:  bus.wb_addr,
                       wstrb: bus.wb_wstrb,
                       data:  bus.wb_data};
    end else if (mrg_hit) begin
      mem[mrg_idx].data <= bus.wb_data;
    end
  end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// Scoreboard bench for dcache_write_buffer.
// Stimulus pushes expectations; a negedge monitor checks every pop.
module tb_dcache_write_buffer;
  localparam int LW = 256;

  typedef struct packed {
    logic [2:0]    t;
    logic [31:0]   a;
    logic [3:0]    s;
    logic [LW-1:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        bridge_empty = 1'b1;
  logic [31:0] rd_chk_addr = 32'h0;
  logic        rd_chk_hit;
  logic        all_empty;

  int   total = 0;
  int   bad = 0;
  ent_t sb[$];
  ent_t me;

  dcache_write_buffer_if #(.LINE_WIDTH(LW)) bus();

  dcache_write_buffer #(
    .LINE_WIDTH(LW), .DEPTH(4), .OFFSET_BITS(5)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .bridge_empty(bridge_empty),
    .rd_chk_addr(rd_chk_addr),
    .rd_chk_hit(rd_chk_hit),
    .all_empty(all_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resetn && bus.data_wr_req && bus.data_wr_rdy) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL mon_extra act=%0h exp=none",
                 bus.data_wr_addr);
      end else begin
        me = sb.pop_front();
        chk("mon_type", LW'(bus.data_wr_type), LW'(me.t));
        chk("mon_addr", LW'(bus.data_wr_addr), LW'(me.a));
        chk("mon_wstrb", LW'(bus.data_wr_wstrb), LW'(me.s));
        chk("mon_data", bus.data_wr_data, me.d);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] t,
                      input logic [31:0] a,
                      input logic [3:0] s,
                      input logic [LW-1:0] d,
                      input int mrg);
    bus.wb_req   = 1'b1;
    bus.wb_type  = t;
    bus.wb_addr  = a;
    bus.wb_wstrb = s;
    bus.wb_data  = d;
    if (bus.wb_rdy) begin
      if (mrg >= 0) sb[mrg].d = d;
      else sb.push_back({t, a, s, d});
    end
    step();
    bus.wb_req = 1'b0;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    bus.data_wr_rdy = 1'b1;
    while (bus.data_wr_req && n < maxc) begin
      step();
      n++;
    end
    chk("drain_done", LW'(bus.data_wr_req), '0);
    bus.data_wr_rdy = 1'b0;
  endtask

  localparam logic [2:0] LN = 3'b100;
  localparam logic [3:0] SF = 4'hF;

  initial begin
    bus.wb_req      = 1'b0;
    bus.wb_type     = 3'b0;
    bus.wb_addr     = 32'h0;
    bus.wb_wstrb    = 4'h0;
    bus.wb_data     = '0;
    bus.data_wr_rdy = 1'b0;

    #1;
    chk("rst_wb_rdy", LW'(bus.wb_rdy), LW'(1));
    chk("rst_req", LW'(bus.data_wr_req), '0);
    chk("rst_hit", LW'(rd_chk_hit), '0);
    chk("rst_all_empty", LW'(all_empty), LW'(1));
    bridge_empty = 1'b0;
    #1;
    chk("rst_all_empty_br", LW'(all_empty), '0);
    bridge_empty = 1'b1;
    #1 resetn = 1'b1;
    step();

    // Single line: latency and hold while the bridge is busy.
    chk("t2_pre_req", LW'(bus.data_wr_req), '0);
    push(LN, 32'h1C000040, SF, {8{32'h11223344}}, -1);
    chk("t2_req", LW'(bus.data_wr_req), LW'(1));
    chk("t2_addr", LW'(bus.data_wr_addr), LW'(32'h1C000040));
    chk("t2_type", LW'(bus.data_wr_type), LW'(LN));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_req", LW'(bus.data_wr_req), LW'(1));
      chk("t2_hold_addr", LW'(bus.data_wr_addr),
          LW'(32'h1C000040));
    end
    drain(4);
    chk("t2_sb_empty", LW'(sb.size()), '0);

    // Fill, refused push while popping, FIFO order.
    push(LN, 32'h0000A000, SF, {8{32'hAAAA0001}}, -1);
    push(3'b010, 32'h0000B004, 4'h3, {8{32'hBBBB0002}}, -1);
    push(LN, 32'h0000C000, SF, {8{32'hCCCC0003}}, -1);
    chk("t3_rdy_3", LW'(bus.wb_rdy), LW'(1));
    push(3'b000, 32'h0000D001, 4'h2, {8{32'hDDDD0004}}, -1);
    chk("t3_full", LW'(bus.wb_rdy), '0);
    bus.data_wr_rdy = 1'b1;
    push(LN, 32'h0000E000, SF, {8{32'hEEEE0005}}, -1);
    chk("t3_after_pop_rdy", LW'(bus.wb_rdy), LW'(1));
    drain(8);
    chk("t3_sb_empty", LW'(sb.size()), '0);

    // Read hazard against a queued line.
    rd_chk_addr = 32'h8000101C;
    #1;
    chk("t4_hit_empty", LW'(rd_chk_hit), '0);
    push(LN, 32'h80001000, SF, {8{32'h80001000}}, -1);
    chk("t4_hit_same", LW'(rd_chk_hit), LW'(1));
    rd_chk_addr = 32'h80001020;
    #1;
    chk("t4_hit_next", LW'(rd_chk_hit), '0);
    rd_chk_addr = 32'h8000101C;
    bus.data_wr_rdy = 1'b1;
    #1;
    chk("t4_hit_popping", LW'(rd_chk_hit), LW'(1));
    step();
    bus.data_wr_rdy = 1'b0;
    chk("t4_hit_gone", LW'(rd_chk_hit), '0);

    // Uncached word store and drain status.
    bridge_empty = 1'b0;
    push(3'b010, 32'h00002004, 4'b0011,
         {{7{32'h5A5A5A5A}}, 32'hDEADBEEF}, -1);
    chk("t5_type", LW'(bus.data_wr_type), LW'(3'b010));
    chk("t5_wstrb", LW'(bus.data_wr_wstrb), LW'(4'b0011));
    chk("t5_word", LW'(bus.data_wr_data[31:0]),
        LW'(32'hDEADBEEF));
    bridge_empty = 1'b1;
    #1;
    chk("t5_all_empty_q", LW'(all_empty), '0);
    bridge_empty = 1'b0;
    drain(4);
    chk("t5_all_empty_br", LW'(all_empty), '0);
    bridge_empty = 1'b1;
    #1;
    chk("t5_all_empty", LW'(all_empty), LW'(1));

    // Async reset with three entries queued.
    push(LN, 32'h00004000, SF, {8{32'h40404040}}, -1);
    push(LN, 32'h00004040, SF, {8{32'h40404141}}, -1);
    push(LN, 32'h00004080, SF, {8{32'h40404242}}, -1);
    rd_chk_addr = 32'h00004040;
    #1;
    chk("t1_hit_pre", LW'(rd_chk_hit), LW'(1));
    resetn = 1'b0;
    #1;
    chk("t1_rst_req", LW'(bus.data_wr_req), '0);
    chk("t1_rst_rdy", LW'(bus.wb_rdy), LW'(1));
    chk("t1_rst_hit", LW'(rd_chk_hit), '0);
    chk("t1_rst_all_empty", LW'(all_empty), LW'(1));
    sb.delete();
    #1 resetn = 1'b1;
    step();
    chk("t1_post_req", LW'(bus.data_wr_req), '0);
    push(LN, 32'h00005000, SF, {8{32'h50505050}}, -1);
    drain(4);
    chk("t1_sb_empty", LW'(sb.size()), '0);

`ifdef WB_MERGE_EN
    // Merge into a non-head line; the head never merges.
    push(LN, 32'h00003000, SF, {8{32'h000A000A}}, -1);
    push(LN, 32'h00003040, SF, {8{32'h000B000B}}, -1);
    push(LN, 32'h00003040, SF, {8{32'h0B2B0B2B}}, 1);
    chk("t6_rdy_merge", LW'(bus.wb_rdy), LW'(1));
    push(LN, 32'h00003000, SF, {8{32'h0A2A0A2A}}, -1);
    chk("t6_rdy_head", LW'(bus.wb_rdy), LW'(1));
    push(LN, 32'h00003080, SF, {8{32'h000C000C}}, -1);
    chk("t6_full", LW'(bus.wb_rdy), '0);
    drain(8);
    chk("t6_sb_empty", LW'(sb.size()), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
